tdm_demux4: RTL
===============

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter W, default 1, width of each data slot in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port din, input, W, serial slot data from the 4:1 time-division mux.
REQ-005 SHALL have port din_valid, input, 1, din carries a valid slot this cycle.
REQ-006 SHALL have port sync, input, 1, frame start; qualified by din_valid, marks slot 0.
REQ-007 SHALL have ports d0, d1, d2, d3, output, W each, demultiplexed frame slots 0..3.
REQ-008 SHALL have port out_valid, output, 1, d0..d3 hold a complete frame.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the frame when out_valid=1.
REQ-010 SHALL have port ovf, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-011 SHALL have port resync_err, output, 1, one-cycle pulse when a partial frame is aborted by sync.

Function
REQ-012 SHALL implement states IDLE, COLLECT and, with parity enabled, PCHK.
- IDLE: ignore beats until din_valid&sync.
- Then store din into slot 0, set slot counter to 1 and enter COLLECT.
REQ-013 SHALL, in COLLECT, store each din_valid beat into the slot selected by a 2-bit counter.
- Counter value s maps slot s to output ds.
- Counter increments per valid beat; cycles with din_valid=0 hold all state.
REQ-014 SHALL complete the frame on the beat that fills slot 3 and return to IDLE.
- Without parity: the frame completes on that beat.
- With parity: the state goes to PCHK instead of completing.
REQ-015 SHALL make a completed frame visible on d0..d3 with out_valid=1 in the cycle after the completing beat (latency 1).
REQ-016 SHALL keep out_valid and d0..d3 stable until a cycle with out_valid&out_ready; out_valid then deasserts the following cycle unless a new frame loads in that same cycle.
REQ-017 SHALL load a frame completing in the same cycle as out_valid&out_ready, so out_valid stays 1 with new data (back-to-back, no bubble).
REQ-018 SHALL, when a frame completes while out_valid=1 and out_ready=0:
- drop the new frame;
- keep the held frame;
- pulse ovf for one cycle.
REQ-019 SHALL, on din_valid&sync while in COLLECT (slot counter not 0):
- discard the partial frame;
- pulse resync_err;
- store din as slot 0 of a new frame.
REQ-020 SHALL treat sync on a beat arriving exactly at frame completion as a new frame start in IDLE, with no error.
REQ-021 SHALL use a collection shift/holding register separate from the d0..d3 output register, so collection continues while the output is held.

Reset
REQ-022 SHALL, on clk edge with rst_n=0:
- set state=IDLE and slot counter=0;
- set d0..d3=0, out_valid=0, ovf=0, resync_err=0;
- abort any in-progress or held frame, with no ovf or resync_err pulse.

Configuration
REQ-023 SHALL support macro TDM_DEMUX_PARITY_EN; when defined, the block SHALL:
- accept a fifth din_valid beat in PCHK carrying even parity: bit 0 = XOR of all bits of slots 0..3;
- complete the frame only if parity matches;
- on mismatch, drop the frame and pulse port perr (output, 1) for one cycle.
REQ-024 SHALL, when TDM_DEMUX_PARITY_EN is undefined:
- have no PCHK state;
- have no perr port;
- complete frames after four beats.

Structure
REQ-025 SHALL place the state enum (IDLE, COLLECT, PCHK), the slot count constant 4 and the slot index width constant 2 in shared package tdm_pkg, for reuse by the matching mux-side framer.
REQ-026 SHALL be a single module; no sub-module is required.

Verification (W=1)
REQ-027 SHALL check: sync on beat 0, beats 1,0,0,1, out_ready=1 -> one cycle later d0=1,d1=0,d2=0,d3=1, out_valid=1; cleared the next cycle.
REQ-028 SHALL check: beats with din_valid gaps of 2 idle cycles between each -> same frame, latency 1 after the last beat.
REQ-029 SHALL check: two frames back-to-back with out_ready=0 -> first frame held, ovf pulses once, second frame never appears.
REQ-030 SHALL check: sync, then 2 beats, then a new sync with frame 0,1,1,0 -> resync_err pulses once, output d0=0,d1=1,d2=1,d3=0.
REQ-031 SHALL check: rst_n=0 after 3 beats -> all outputs 0 next cycle; a subsequent full frame decodes correctly.
REQ-032 SHALL check, with TDM_DEMUX_PARITY_EN: frame 1,1,1,0 with parity 1 -> accepted; the same frame with parity 0 -> perr pulse, out_valid stays 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer and its mux-side framer.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PCHK    = 2'd2
  } tdm_state_e;

  localparam int TDM_SLOTS = 4;
  localparam int TDM_IDX_W = 2;
  localparam logic [TDM_IDX_W-1:0] TDM_LAST_SLOT = 2'd3;

endpackage

// File: rtl/tdm_demux4.sv
// Demultiplexes a 4-slot TDM stream into a held output frame with ready handshake.
// Optional trailing even-parity beat per frame when TDM_DEMUX_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a valid sync beat (slot 0)
// COLLECT | filling slots 1..3 of the collection register
// PCHK    | waiting for the parity beat (parity build only)
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ovf,
  output logic         resync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic         perr
`endif
);

  tdm_state_e                  state_q, state_d;
  logic [TDM_IDX_W-1:0]        cnt_q, cnt_d;
  logic [TDM_SLOTS-1:0][W-1:0] coll_q, coll_d;
  logic [TDM_SLOTS-1:0][W-1:0] dout_q, dout_d;
  logic                        out_valid_q, out_valid_d;
  logic                        ovf_q, ovf_d;
  logic                        rerr_q, rerr_d;
  logic                        frame_done;
  logic                        resync_evt;
`ifdef TDM_DEMUX_PARITY_EN
  logic                        perr_q, perr_d;
  logic                        perr_evt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coll_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    coll_d     = coll_q;
    frame_done = 1'b0;
    resync_evt = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_evt   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid && sync) begin
          coll_d[0] = din;
          cnt_d     = 2'd1;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (sync) begin
            // counter is never 0 here, so any sync aborts a partial frame
            resync_evt = 1'b1;
            coll_d[0]  = din;
            cnt_d      = 2'd1;
          end else begin
            coll_d[cnt_q] = din;
            if (cnt_q == TDM_LAST_SLOT) begin
              cnt_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
              state_d = PCHK;
`else
              state_d    = IDLE;
              frame_done = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      PCHK: begin
        if (din_valid) begin
          state_d = IDLE;
          if (din[0] == ^coll_q) frame_done = 1'b1;
          else                   perr_evt   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    ovf_d       = 1'b0;
    rerr_d      = resync_evt;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d      = perr_evt;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (frame_done) begin
      if (out_valid_q && !out_ready) begin
        ovf_d = 1'b1;
      end else begin
        dout_d      = coll_d;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      rerr_q      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      rerr_q      <= rerr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign d0         = dout_q[0];
  assign d1         = dout_q[1];
  assign d2         = dout_q[2];
  assign d3         = dout_q[3];
  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign resync_err = rerr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign perr       = perr_q;
`endif

endmodule
